// File: rtl/queue64_pkg.sv
// Shared sizing constants for the 64-entry first-word-fall-through queue.
//   QDEPTH : number of RAM words
//   QAW    : RAM address width (pointer width)
//   QCW    : occupancy counter width (must hold 0..QDEPTH)
package queue64_pkg;

  localparam int QDEPTH = 64;
  localparam int QAW    = 6;
  localparam int QCW    = 7;

endpackage : queue64_pkg

// File: rtl/dpram64.sv
// 64x1 distributed dual-port RAM: synchronous write port, asynchronous read
// port on a separate address. One instance stores one bit of the queue word.
//   clk  : write clock
//   we   : write enable
//   a    : write address
//   d    : write data bit
//   dpra : read address
//   dpo  : asynchronous read data bit, RAM[dpra]
module dpram64 (
  input  logic       clk,
  input  logic       we,
  input  logic [5:0] a,
  input  logic       d,
  input  logic [5:0] dpra,
  output logic       dpo
);

  logic mem [0:63];

  // NOTE: storage has no reset; the controller never reads a word before it
  // has been written, and a reset port would stop this mapping onto LUT RAM.
  always_ff @(posedge clk) begin
    if (we) mem[a] <= d;
  end

  assign dpo = mem[dpra];

endmodule : dpram64

// File: rtl/queue64_ctl.sv
// Control path of the 64-entry FWFT queue: RAM pointers, RAM occupancy,
// output-register valid flag, total count, full/empty flags and sticky error.
//   CLK, Reset : clock, asynchronous active-high reset
//   wr_en      : enqueue request (accepted when not full)
//   rd_en      : dequeue request (accepted when the output register is valid)
//   wa, ra, we : RAM write address, read address, write enable
//   load       : capture RAM[ra] into the output register at this edge
//   full       : registered, count == 64
//   empty      : registered, output register holds no word
//   count      : words held in RAM plus output register
//   err        : sticky, write while full or read while empty
module queue64_ctl
  import queue64_pkg::*;
(
  input  logic           CLK,
  input  logic           Reset,
  input  logic           wr_en,
  input  logic           rd_en,
  output logic [QAW-1:0] wa,
  output logic [QAW-1:0] ra,
  output logic           we,
  output logic           load,
  output logic           full,
  output logic           empty,
  output logic [QCW-1:0] count,
  output logic           err
);

  logic [QAW-1:0] wp, rp;
  logic [QCW-1:0] rc, rc_next, count_next;
  logic           ov, ov_next, rd_acc;

  assign wa = wp;
  assign ra = rp;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    we         = 1'b0;
    rd_acc     = 1'b0;
    load       = 1'b0;
    ov_next    = ov;
    rc_next    = rc;
    count_next = count;

    we     = wr_en & ~full;
    rd_acc = rd_en & ov;
    // Refill the output register when it is free or being drained this edge.
    load   = (rc != '0) & (~ov | rd_acc);

    if (load)        ov_next = 1'b1;
    else if (rd_acc) ov_next = 1'b0;

    rc_next    = rc + QCW'(we) - QCW'(load);
    count_next = count + QCW'(we) - QCW'(rd_acc);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      wp    <= '0;
      rp    <= '0;
      rc    <= '0;
      ov    <= 1'b0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      err   <= 1'b0;
    end else begin
      if (we)   wp <= wp + QAW'(1);
      if (load) rp <= rp + QAW'(1);
      rc    <= rc_next;
      ov    <= ov_next;
      count <= count_next;
      full  <= (count_next == QCW'(QDEPTH));
      empty <= ~ov_next;
      err   <= err | (wr_en & full) | (rd_en & ~ov);
    end
  end

endmodule : queue64_ctl

// File: rtl/queue64_fwft.sv
// 64-entry first-word-fall-through queue. Storage is WIDTH slices of dpram64;
// the head word sits in a registered output stage.
//   CLK, Reset : clock, asynchronous active-high reset
//   wr_data    : word to enqueue;  wr_en : enqueue request
//   rd_en      : dequeue request;  rd_data : head word, valid when !empty
//   full, empty, count, err : registered status (see queue64_ctl)
module queue64_fwft
  import queue64_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_en,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [QCW-1:0]   count,
  output logic             err
);

  logic [QAW-1:0]   wa, ra;
  logic             we, load;
  logic [WIDTH-1:0] dpo;

  queue64_ctl u_ctl (
    .CLK   (CLK),
    .Reset (Reset),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .wa    (wa),
    .ra    (ra),
    .we    (we),
    .load  (load),
    .full  (full),
    .empty (empty),
    .count (count),
    .err   (err)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    dpram64 u_ram (
      .clk  (CLK),
      .we   (we),
      .a    (wa),
      .d    (wr_data[i]),
      .dpra (ra),
      .dpo  (dpo[i])
    );
  end

  // Head-of-queue register; holds its last word once the queue drains.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)     rd_data <= '0;
    else if (load) rd_data <= dpo;
  end

endmodule : queue64_fwft

// File: tb/tb_queue64_fwft.sv
// Self-checking bench for queue64_fwft: directed scenarios plus a random
// phase, all compared against a word-level queue model.
module tb_queue64_fwft;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [31:0] wr_data;
  logic        wr_en, rd_en;
  logic        full, empty, err;
  logic [31:0] rd_data;
  logic [6:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: every held word in arrival order, whether the head is
  // presented on rd_data, the expected rd_data value and the sticky error.
  logic [31:0] q[$];
  bit          m_ov;
  bit          m_err;
  logic [31:0] m_rd;

  queue64_fwft #(.WIDTH(32)) dut (
    .CLK     (CLK),
    .Reset   (Reset),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .full    (full),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .count   (count),
    .err     (err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    q.delete();
    m_ov  = 1'b0;
    m_err = 1'b0;
    m_rd  = '0;
  endfunction

  // One clock edge of the queue, expressed at word level.
  function automatic void model_edge(bit w, bit r, logic [31:0] d);
    int held, ram_words;
    bit wr_acc, rd_acc;
    held      = q.size();
    ram_words = held - int'(m_ov);
    wr_acc    = w && (held < 64);
    rd_acc    = r && m_ov;
    if (w && !wr_acc) m_err = 1'b1;
    if (r && !m_ov)   m_err = 1'b1;
    if (rd_acc) void'(q.pop_front());
    if (ram_words != 0 && (!m_ov || rd_acc)) begin
      m_ov = 1'b1;
      m_rd = q[0];
    end else if (rd_acc) begin
      m_ov = 1'b0;
    end
    if (wr_acc) q.push_back(d);
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".empty"}, 32'(empty), 32'(!m_ov));
    check({tag, ".full"},  32'(full),  32'(q.size() == 64));
    check({tag, ".count"}, 32'(count), 32'(q.size()));
    check({tag, ".err"},   32'(err),   32'(m_err));
    check({tag, ".rd"},    rd_data,    m_rd);
  endtask

  // Drive one cycle at the falling edge, sample #1 after the rising edge.
  task automatic step(input bit w, input bit r, input logic [31:0] d, input string tag);
    @(negedge CLK);
    wr_en   = w;
    rd_en   = r;
    wr_data = d;
    model_edge(w, r, d);
    @(posedge CLK);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    wr_en = 1'b0;
    rd_en = 1'b0;
    Reset = 1'b1;
    model_clear();
    @(negedge CLK);
    Reset = 1'b0;
    #1;
    compare_all("reset");
  endtask

  initial begin
    Reset   = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    model_clear();
    repeat (3) @(negedge CLK);
    Reset = 1'b0;
    #1;
    compare_all("por");

    // Single write: hidden after edge E, visible after E+1.
    step(1, 0, 32'hA5A5_A5A5, "t1_wr");
    check("t1_empty_E", 32'(empty), 32'd1);
    step(0, 0, '0, "t1_idle");
    check("t1_empty_E1", 32'(empty), 32'd0);
    check("t1_rd", rd_data, 32'hA5A5_A5A5);
    check("t1_count", 32'(count), 32'd1);
    // Write and read with an empty RAM: one-cycle empty bubble, then reload.
    step(1, 1, 32'h5A5A_5A5A, "t1_wrrd");
    check("t1_bubble", 32'(empty), 32'd1);
    step(0, 0, '0, "t1_reload");
    check("t1_reload_rd", rd_data, 32'h5A5A_5A5A);

    // Fill to 64, overflow attempt, then drain in order.
    do_reset();
    for (int i = 0; i < 64; i++) step(1, 0, 32'(i), "t2_fill");
    check("t2_full", 32'(full), 32'd1);
    check("t2_count64", 32'(count), 32'd64);
    step(1, 0, 32'hFFFF, "t2_ovf");
    check("t2_err", 32'(err), 32'd1);
    check("t2_count_hold", 32'(count), 32'd64);
    for (int i = 0; i < 64; i++) begin
      check("t2_nobubble", 32'(empty), 32'd0);
      check("t2_head", rd_data, 32'(i));
      step(0, 1, '0, "t2_drain");
    end
    check("t2_empty", 32'(empty), 32'd1);
    check("t2_count0", 32'(count), 32'd0);

    // Steady state at count 5 with simultaneous traffic, wrapping pointers.
    do_reset();
    for (int n = 0; n < 5; n++) step(1, 0, 32'h100 + 32'(n), "t3_prime");
    for (int k = 0; k < 200; k++) begin
      step(1, 1, 32'h100 + 32'(k + 5), "t3_stream");
      check("t3_count", 32'(count), 32'd5);
      check("t3_delay", rd_data, 32'h100 + 32'(k + 1));
    end

    // Full with simultaneous write and read.
    do_reset();
    for (int i = 0; i < 64; i++) step(1, 0, 32'h4000 + 32'(i), "t4_fill");
    check("t4_head0", rd_data, 32'h4000);
    step(1, 1, 32'hDEAD_BEEF, "t4_wrrd");
    check("t4_count", 32'(count), 32'd63);
    check("t4_err", 32'(err), 32'd1);
    check("t4_head1", rd_data, 32'h4001);

    // Read on empty after reset.
    do_reset();
    step(0, 1, '0, "t5_rdempty");
    check("t5_err", 32'(err), 32'd1);
    check("t5_rd", rd_data, 32'd0);
    check("t5_count", 32'(count), 32'd0);

    // Asynchronous reset mid-cycle at count 30.
    do_reset();
    for (int i = 0; i < 30; i++) step(1, 0, 32'h7000 + 32'(i), "t6_fill");
    step(1, 1, 32'h1234, "t6_pre");  // leaves count 30 and err clear
    check("t6_count30", 32'(count), 32'd30);
    step(0, 1, '0, "t6_mk_err");
    @(negedge CLK);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2;
    Reset = 1'b1;
    #1;
    model_clear();
    check("t6_async_empty", 32'(empty), 32'd1);
    check("t6_async_full",  32'(full),  32'd0);
    check("t6_async_count", 32'(count), 32'd0);
    check("t6_async_err",   32'(err),   32'd0);
    check("t6_async_rd",    rd_data,    32'd0);
    @(negedge CLK);
    Reset = 1'b0;
    step(1, 0, 32'h1, "t6_wr");
    step(0, 0, '0, "t6_idle");
    check("t6_rd1", rd_data, 32'h1);
    check("t6_vis", 32'(empty), 32'd0);

    // Random traffic with shifting write/read bias to visit full and empty.
    do_reset();
    for (int p = 0; p < 6; p++) begin
      int wp_pct, rp_pct;
      wp_pct = (p % 3 == 0) ? 85 : (p % 3 == 1) ? 20 : 55;
      rp_pct = (p % 3 == 0) ? 25 : (p % 3 == 1) ? 80 : 50;
      for (int c = 0; c < 250; c++) begin
        step($urandom_range(0, 99) < wp_pct, $urandom_range(0, 99) < rp_pct,
             $urandom, "rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_queue64_fwft
